// File: rtl/switch_debouncer4_pkg.sv
// switch_debouncer4_pkg: shared state encoding and switch bit positions
package switch_debouncer4_pkg;
  typedef enum logic {ST_STABLE = 1'b0, ST_COUNTING = 1'b1} state_t;
  localparam int N_CH  = 4;
  localparam int A_BIT = 3;
  localparam int B_BIT = 2;
  localparam int C_BIT = 1;
  localparam int D_BIT = 0;
endpackage

// File: rtl/switch_debouncer4_if.sv
// switch_debouncer4_if: raw switch inputs and debounced outputs
interface switch_debouncer4_if;
  logic       tick;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic [3:0] changed;
  modport master (output tick, sw_in, input sw_out, changed);
  modport slave (input tick, sw_in, output sw_out, changed);
endinterface

// File: rtl/switch_debouncer4_channel.sv
// debounce_channel: two-flop synchroniser followed by a tick-paced debounce FSM
module debounce_channel
  import switch_debouncer4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic chg
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic             s1, s2, dout_nx, chg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  state_t           state, state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      dout  <= 1'b0;
      chg   <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      state <= state_nx;
      cnt   <= cnt_nx;
      dout  <= dout_nx;
      chg   <= chg_nx;
    end
  end
  // A sample matching the current output always resets the count, whether idle or mid-glitch
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dout_nx  = dout;
    chg_nx   = 1'b0;
    if (tick) begin
      if (s2 == dout) begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
      end else if (state == ST_STABLE) begin
        state_nx = ST_COUNTING;
        cnt_nx   = CNT_W'(1);
      end else if (cnt == LAST) begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
        dout_nx  = s2;
        chg_nx   = 1'b1;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_debouncer4.sv
// switch_debouncer4: four independent debounced switch channels
module switch_debouncer4
  import switch_debouncer4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 2
) (
  input logic              clk,
  input logic              rst,
  switch_debouncer4_if.slave bus
);
  logic [N_CH-1:0] sw_out, changed;
  assign bus.sw_out  = sw_out;
  assign bus.changed = changed;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .tick(bus.tick),
      .din (bus.sw_in[i]),
      .dout(sw_out[i]),
      .chg (changed[i])
    );
  end
endmodule

// File: tb/tb_switch_debouncer4.sv
// tb_switch_debouncer4: directed steps with a cycle-stamped expectation scoreboard
module tb_switch_debouncer4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  switch_debouncer4_if bus();
  switch_debouncer4 #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int         due;
    string      tag;
    logic [3:0] so;
    logic [3:0] ch;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc++;
  function automatic void expect_at(int due, string tag, logic [3:0] so, logic [3:0] ch);
    exp_t e;
    e.due = due;
    e.tag = tag;
    e.so  = so;
    e.ch  = ch;
    sb.push_back(e);
  endfunction
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        tests++;
        assert (bus.sw_out === sb[i].so) else begin
          fails++;
          $error("FAIL %s.sw_out cyc=%0d observed=%h expected=%h", sb[i].tag, cyc, bus.sw_out, sb[i].so);
        end
        tests++;
        assert (bus.changed === sb[i].ch) else begin
          fails++;
          $error("FAIL %s.changed cyc=%0d observed=%h expected=%h", sb[i].tag, cyc, bus.changed, sb[i].ch);
        end
        sb.delete(i);
      end
    end
  end
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int t;
    int w;
    rst       = 1'b1;
    bus.sw_in = 4'hF;
    bus.tick  = 1'b1;
    for (int k = 1; k <= 3; k++) expect_at(k, "reset", 4'h0, 4'h0);
    step(3);
    rst       = 1'b0;
    bus.sw_in = 4'h0;
    t = cyc;
    for (int k = 1; k <= 3; k++) expect_at(t + k, "idle", 4'h0, 4'h0);
    step(3);
    t = cyc;
    bus.sw_in = 4'h8;
    expect_at(t + 5, "step_pre", 4'h0, 4'h0);
    expect_at(t + 6, "step_acc", 4'h8, 4'h8);
    expect_at(t + 7, "step_post", 4'h8, 4'h0);
    step(8);
    t = cyc;
    bus.sw_in = 4'hC;
    for (int k = 1; k <= 10; k++) expect_at(t + k, "glitch", 4'h8, 4'h0);
    step(3);
    bus.sw_in = 4'h8;
    step(8);
    t = cyc;
    bus.sw_in = 4'h9;
    for (int k = 1; k <= 21; k++)
      expect_at(t + k, "prescale", (k < 18) ? 4'h8 : 4'h9, (k == 18) ? 4'h1 : 4'h0);
    for (int k = 1; k <= 22; k++) begin
      bus.tick = (k % 4 == 2);
      step(1);
    end
    bus.tick = 1'b1;
    t = cyc;
    bus.sw_in = 4'h0;
    expect_at(t + 5, "fall_pre", 4'h9, 4'h0);
    expect_at(t + 6, "fall_acc", 4'h0, 4'h9);
    expect_at(t + 7, "fall_post", 4'h0, 4'h0);
    step(8);
    t = cyc;
    bus.sw_in = 4'hF;
    expect_at(t + 5, "simul_pre", 4'h0, 4'h0);
    expect_at(t + 6, "simul_acc", 4'hF, 4'hF);
    expect_at(t + 7, "simul_post", 4'hF, 4'h0);
    step(8);
    t = cyc;
    bus.sw_in = 4'h5;
    expect_at(t + 5, "part_pre", 4'hF, 4'h0);
    expect_at(t + 6, "part_acc", 4'h5, 4'hA);
    expect_at(t + 7, "part_post", 4'h5, 4'h0);
    step(8);
    t = cyc;
    bus.sw_in = 4'h7;
    for (int k = 1; k <= 3; k++) expect_at(t + k, "midrst_cnt", 4'h5, 4'h0);
    for (int k = 4; k <= 9; k++) expect_at(t + k, "midrst_wait", 4'h0, 4'h0);
    expect_at(t + 10, "midrst_acc", 4'h7, 4'h7);
    expect_at(t + 11, "midrst_post", 4'h7, 4'h0);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      step(1);
      w++;
    end
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
